card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
- Producer of cards for the hand-level game FSM. Holds a 52-card deck, shuffles it with a seeded LFSR-driven Fisher-Yates pass, then delivers one card per valid/ready transfer.
- Sits between the top-level start/seed logic and game_fsm. game_fsm pulls hole cards, flop, turn and river from this block in deal order.

Parameters:
- LFSR_W, 16, width of the shuffle LFSR and of the seed.
- ZERO_SEED_SUB, 16'hACE1, value substituted when the seed is zero (an all-zero LFSR locks up).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- shuffle_start  in  1  single-cycle pulse: restart the deck and shuffle.
- seed  in  LFSR_W  shuffle seed, sampled on the shuffle_start cycle.
- deal_ready  in  1  consumer accepts deal_card this cycle.
- deal_valid  out  1  deal_card is valid.
- deal_card  out  6  card_t from poker_types.svh, packed {suit[1:0], rank[3:0]}.
- cards_remaining  out  6  undealt cards, 0..52.
- busy  out  1  shuffle in progress.

Behaviour:
- Card encoding: deck index k (0..51) maps to suit = k/13 and rank = (k%13)+2, so rank runs 2..14 with ace = 14.
- Storage: deck[0:51] of 6-bit entries, 6-bit deal pointer ptr, LFSR, 6-bit swap index i.
- States and transitions:
  - IDLE → INIT on shuffle_start.
  - INIT (1 cycle):
    - every deck[k] loaded with the encoding of k, in parallel;
    - LFSR <= (seed==0 ? ZERO_SEED_SUB : seed); i <= 51; ptr <= 0;
    - → SHUFFLE.
  - SHUFFLE (51 cycles, i = 51 down to 1):
    - j = (lfsr * (i+1)) >> LFSR_W, using the current lfsr, so 0 <= j <= i;
    - swap deck[i] and deck[j] in the same cycle (j==i is a no-op);
    - the LFSR steps once per cycle on the same edge;
    - i decrements; after the i==1 cycle → READY.
  - READY:
    - deal_valid=1, deal_card=deck[ptr];
    - on deal_valid&&deal_ready, ptr increments;
    - the transfer with ptr==51 → EMPTY.
  - EMPTY: deal_valid=0. shuffle_start → INIT.
- LFSR: Galois, right-shifting, taps mask 16'hB400 (x^16+x^14+x^13+x^11+1). Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- Latency: shuffle_start sampled at edge N puts the block in INIT for cycle N+1. deal_valid first rises 52 cycles after the start edge (1 INIT cycle + 51 SHUFFLE cycles).
- shuffle_start handling:
  - Accepted in IDLE, READY or EMPTY.
  - Ignored while busy (INIT/SHUFFLE); seed is not re-sampled.
  - In READY, if deal_valid&&deal_ready coincides with shuffle_start, that transfer completes, then the block restarts.
- Outputs:
  - deal_valid is combinational from state: 1 only in READY. It must not depend on deal_ready.
  - deal_card is 0 whenever deal_valid=0.
  - cards_remaining = 52-ptr in READY; 0 in IDLE, INIT, SHUFFLE and EMPTY.
  - busy = 1 in INIT and SHUFFLE only.
- Holding: while deal_valid=1 && deal_ready=0, deal_card holds stable.
- Reset: an asynchronous assert mid-shuffle or mid-deal forces the following, immediately:
  - state IDLE, ptr 0, i 0, LFSR ZERO_SEED_SUB, all deck entries 0;
  - deal_valid 0, deal_card 0, cards_remaining 0, busy 0.
- Permutation invariant: after any completed shuffle the 52 deck entries are a permutation of the 52 encodings. There are no duplicate cards in one deck.

Test Plan:
- Reset then shuffle_start with seed=16'h1234 → busy=1 for exactly 52 cycles. deal_valid rises on the 52nd cycle after the start edge, and cards_remaining=52.
- Hold deal_ready=1 for 60 cycles → exactly 52 transfers.
  - All 52 cards are distinct, with suits 0..3 and ranks 2..14 each present.
  - cards_remaining counts 52→0, then deal_valid=0 and state is EMPTY.
- Two shuffles with the same seed=16'h1234 → identical 52-card sequences. A shuffle with seed=16'h4321 → a different sequence.
- seed=0 → same sequence as seed=16'hACE1. No lockup; 52 distinct cards.
- Backpressure: after READY, toggle deal_ready randomly → deal_card stable while deal_ready=0, no card skipped or repeated. A shuffle_start pulse during SHUFFLE → ignored, latency unchanged.
- Assert reset at cycle 20 of SHUFFLE → all outputs 0 immediately. A fresh shuffle_start then completes normally with 52 distinct cards.

Source files
------------

// File: rtl/card_dealer.sv
// 52-card deck source: seeded Galois-LFSR Fisher-Yates shuffle, then one card
// per valid/ready transfer in deck order.
module card_dealer #(
    parameter int unsigned            LFSR_W        = 16,
    parameter logic [LFSR_W-1:0]      ZERO_SEED_SUB = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shuffle_start,
    input  logic [LFSR_W-1:0] seed,
    input  logic              deal_ready,
    output logic              deal_valid,
    output logic [5:0]        deal_card,
    output logic [5:0]        cards_remaining,
    output logic              busy
);

    localparam int unsigned N_CARDS = 52;
    localparam int unsigned CARD_W  = 6;
    localparam int unsigned PROD_W  = LFSR_W + CARD_W;
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_READY,
        S_EMPTY
    } state_t;

    state_t              state_q;
    logic [CARD_W-1:0]   deck_q [N_CARDS];
    logic [CARD_W-1:0]   ptr_q;
    logic [CARD_W-1:0]   i_q;
    logic [LFSR_W-1:0]   lfsr_q;

    logic [LFSR_W-1:0]   lfsr_d;
    logic [LFSR_W-1:0]   seed_d;
    logic [PROD_W-1:0]   prod_d;
    logic [CARD_W-1:0]   j_d;
    logic                xfer_d;

    assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    assign seed_d = (seed == '0) ? ZERO_SEED_SUB : seed;

    // Scale the LFSR into 0..i: upper bits of lfsr * (i+1)
    assign prod_d = PROD_W'(lfsr_q) * PROD_W'(i_q + CARD_W'(1));
    assign j_d    = prod_d[PROD_W-1 -: CARD_W];

    assign deal_valid      = (state_q == S_READY);
    assign xfer_d          = deal_valid && deal_ready;
    assign deal_card       = deal_valid ? deck_q[ptr_q] : '0;
    assign cards_remaining = deal_valid ? (CARD_W'(N_CARDS) - ptr_q) : '0;
    assign busy            = (state_q == S_INIT) || (state_q == S_SHUFFLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            i_q     <= '0;
            lfsr_q  <= ZERO_SEED_SUB;
            for (int unsigned k = 0; k < N_CARDS; k++) begin
                deck_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_EMPTY: begin
                    if (shuffle_start) begin
                        lfsr_q  <= seed_d;
                        state_q <= S_INIT;
                    end
                end
                S_INIT: begin
                    for (int unsigned k = 0; k < N_CARDS; k++) begin
                        deck_q[k] <= {2'(k / 13), 4'((k % 13) + 2)};
                    end
                    i_q     <= CARD_W'(N_CARDS - 1);
                    ptr_q   <= '0;
                    state_q <= S_SHUFFLE;
                end
                S_SHUFFLE: begin
                    // j == i writes the same value twice, so no special case
                    deck_q[i_q] <= deck_q[j_d];
                    deck_q[j_d] <= deck_q[i_q];
                    lfsr_q      <= lfsr_d;
                    i_q         <= i_q - CARD_W'(1);
                    if (i_q == CARD_W'(1)) begin
                        state_q <= S_READY;
                    end
                end
                S_READY: begin
                    if (xfer_d) begin
                        ptr_q <= ptr_q + CARD_W'(1);
                    end
                    if (shuffle_start) begin
                        lfsr_q  <= seed_d;
                        state_q <= S_INIT;
                    end else if (xfer_d && (ptr_q == CARD_W'(N_CARDS - 1))) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Random-seed / random-backpressure bench for card_dealer against an
// array-based Fisher-Yates reference model.
module tb_card_dealer;

    logic        clk = 1'b0;
    logic        reset;
    logic        shuffle_start;
    logic [15:0] seed;
    logic        deal_ready;
    logic        deal_valid;
    logic [5:0]  deal_card;
    logic [5:0]  cards_remaining;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_seq [52];
    int got_seq [52];
    int seq_a   [52];
    int seq_b   [52];

    card_dealer dut (
        .clk             (clk),
        .reset           (reset),
        .shuffle_start   (shuffle_start),
        .seed            (seed),
        .deal_ready      (deal_ready),
        .deal_valid      (deal_valid),
        .deal_card       (deal_card),
        .cards_remaining (cards_remaining),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: expected deal order for a seed, built from the card/shuffle rules
    task automatic build_model(input logic [15:0] s);
        int d [52];
        int l;
        int j;
        int t;
        l = (s == 16'h0) ? 'hACE1 : int'(s);
        for (int k = 0; k < 52; k++) d[k] = (k / 13) * 16 + (k % 13) + 2;
        for (int i = 51; i >= 1; i--) begin
            j    = (l * (i + 1)) / 65536;
            t    = d[i];
            d[i] = d[j];
            d[j] = t;
            l    = (l / 2) ^ (((l % 2) == 1) ? 'hB400 : 0);
        end
        exp_seq = d;
    endtask

    // Pulse start; optionally pulse start again at cycle glitch_at while busy
    task automatic do_start(input logic [15:0] s, input int glitch_at);
        int cyc;
        int busy_cnt;
        shuffle_start = 1'b1;
        seed          = s;
        tick();
        shuffle_start = 1'b0;
        seed          = 16'($urandom);
        check("busy_after_start", busy, 1);
        check("valid_after_start", deal_valid, 0);
        cyc      = 0;
        busy_cnt = 0;
        while (!deal_valid && cyc < 200) begin
            if (busy) busy_cnt++;
            if (cyc == glitch_at) begin
                shuffle_start = 1'b1;
                seed          = 16'($urandom);
            end
            tick();
            shuffle_start = 1'b0;
            cyc++;
        end
        check("start_latency", cyc, 52);
        check("busy_cycles", busy_cnt, 52);
        check("busy_in_ready", busy, 0);
        check("remaining_full", cards_remaining, 52);
        build_model(s);
    endtask

    // mode 0: ready held high for 60 cycles; mode 1: random ready until deck empty
    task automatic drain(input int mode);
        int  idx;
        int  limit;
        int  nd;
        bit  seen [64];
        foreach (seen[k]) seen[k] = 1'b0;
        idx   = 0;
        limit = (mode == 0) ? 60 : 400;
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (mode == 1 && idx >= 52) break;
            deal_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (deal_valid) begin
                if (idx < 52) begin
                    check("card", deal_card, exp_seq[idx]);
                    check("remaining", cards_remaining, 52 - idx);
                end
                if (deal_ready) begin
                    if (idx < 52) begin
                        got_seq[idx]    = int'(deal_card);
                        seen[deal_card] = 1'b1;
                    end
                    idx++;
                end
            end else if (idx < 52) begin
                check("card_when_invalid", deal_card, 0);
            end
            tick();
        end
        deal_ready = 1'b0;
        check("transfers", idx, 52);
        check("empty_valid", deal_valid, 0);
        check("empty_card", deal_card, 0);
        check("empty_remaining", cards_remaining, 0);
        check("empty_busy", busy, 0);
        nd = 0;
        for (int su = 0; su < 4; su++)
            for (int r = 2; r <= 14; r++)
                if (seen[su * 16 + r]) nd++;
        check("distinct_cards", nd, 52);
    endtask

    function automatic int seq_diff(input int a [52], input int b [52]);
        int n = 0;
        for (int k = 0; k < 52; k++) if (a[k] != b[k]) n++;
        return n;
    endfunction

    initial begin
        reset         = 1'b1;
        shuffle_start = 1'b0;
        seed          = 16'h0;
        deal_ready    = 1'b0;
        tick();
        check("rst_valid", deal_valid, 0);
        check("rst_card", deal_card, 0);
        check("rst_remaining", cards_remaining, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        check("idle_valid", deal_valid, 0);

        do_start(16'h1234, -1);
        drain(0);
        seq_a = got_seq;

        // Repeat with the same seed, a start pulse mid-shuffle and backpressure
        do_start(16'h1234, 30);
        drain(1);
        check("same_seed_repeat", seq_diff(got_seq, seq_a), 0);

        do_start(16'h4321, -1);
        drain(0);
        check("diff_seed_differs", seq_diff(got_seq, seq_a) > 0, 1);

        do_start(16'hACE1, -1);
        drain(0);
        seq_b = got_seq;
        do_start(16'h0000, -1);
        drain(1);
        check("zero_seed_sub", seq_diff(got_seq, seq_b), 0);

        // Restart from READY with a coinciding transfer
        do_start(16'h5A5A, -1);
        deal_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("ready_mid_deal", cards_remaining, 47);
        do_start(16'h0F0F, -1);
        deal_ready = 1'b0;
        drain(1);

        // Asynchronous reset in the middle of the shuffle
        shuffle_start = 1'b1;
        seed          = 16'hBEEF;
        tick();
        shuffle_start = 1'b0;
        for (int k = 0; k < 21; k++) tick();
        check("mid_shuffle_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", deal_valid, 0);
        check("async_rst_card", deal_card, 0);
        check("async_rst_remaining", cards_remaining, 0);
        check("async_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        tick();
        do_start(16'hBEEF, -1);
        drain(1);

        for (int r = 0; r < 3; r++) begin
            do_start(16'($urandom), int'($urandom_range(1, 50)));
            drain(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
